// File: rtl/mul_hilo_ctrl.sv
// Multicycle control around the EX-stage 32x32 unsigned array multiplier.
// Owns HI/LO, sign-corrects the unsigned product and services MTHI/MTLO.
module mul_hilo_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mthi,
  input  logic                 mtlo,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  // Issue protocol: start is a request taken only while busy is low
  // (IDLE or DONE); there is no ready back-pressure, the issuer must honour busy.

  localparam int PW = 2 * WIDTH;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              neg, neg_n;
  logic [WIDTH-1:0]  mul_a_q, mul_a_n;
  logic [WIDTH-1:0]  mul_b_q, mul_b_n;
  logic [WIDTH-1:0]  hi_q, hi_n;
  logic [WIDTH-1:0]  lo_q, lo_n;
  logic [PW-1:0]     prod_fix;
  logic [WIDTH-1:0]  abs_a, abs_b;

  // Most-negative input negates to itself, which is still the right unsigned magnitude.
  assign abs_a    = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign abs_b    = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
  assign prod_fix = neg ? (~mul_product + PW'(1)) : mul_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      neg     <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      neg     <= neg_n;
      mul_a_q <= mul_a_n;
      mul_b_q <= mul_b_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    neg_n   = neg;
    mul_a_n = mul_a_q;
    mul_b_n = mul_b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      IDLE, DONE: begin
        if (mthi) hi_n = wdata;
        if (mtlo) lo_n = wdata;
        if (start) begin
          mul_a_n = signed_op ? abs_a : op_a;
          mul_b_n = signed_op ? abs_b : op_b;
          neg_n   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          cnt_n   = CNT_INIT;
          state_n = WAIT;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        // Operands stay frozen here so the multiplier path sees stable inputs.
        if (cnt == '0) begin
          {hi_n, lo_n} = prod_fix;
          state_n      = DONE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state == WAIT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
Multicycle control stage that wraps the combinational 32x32 unsigned array multiplier in the EX stage and owns the architectural HI/LO registers.
- Accepts MULT/MULTU requests and presents operand magnitudes to the multiplier.
- Holds those operands stable for a fixed settle window, then sign-corrects the 64-bit product and writes HI/LO.
- Services MTHI/MTLO and drives busy for the hazard unit to stall MFHI/MFLO/MULT issue.

Parameters:
MUL_CYCLES, 4, cycles mul_a/mul_b are held before product is sampled (multicycle path budget); legal range 1..15
WIDTH, 32, operand width; HI/LO each WIDTH, product 2*WIDTH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  multiply request, sampled when state is IDLE or DONE
signed_op  in  1  1 = MULT (two's complement), 0 = MULTU
op_a  in  WIDTH  rs operand
op_b  in  WIDTH  rt operand
mul_a  out  WIDTH  registered magnitude of op_a, to multiplier A
mul_b  out  WIDTH  registered magnitude of op_b, to multiplier B
mul_product  in  2*WIDTH  unsigned product from multiplier
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  high while state is WAIT
done  out  1  one-cycle pulse, HI/LO just updated by a multiply

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, neg=0, mul_a=mul_b=0, hi=lo=0, done=0, busy=0. Reset mid-WAIT abandons the operation; HI/LO stay 0.
- FSM states: IDLE, WAIT, DONE. busy = (state==WAIT); done = (state==DONE).
- IDLE/DONE + start:
  - mul_a <= signed_op ? |op_a| : op_a (same rule for mul_b).
  - |x| = two's-complement negate when x[WIDTH-1]=1; 0x80000000 maps to 0x80000000, which is correct as an unsigned magnitude.
  - neg <= signed_op & (op_a[MSB] ^ op_b[MSB]); cnt <= MUL_CYCLES-1; state <= WAIT.
- IDLE/DONE without start: DONE -> IDLE; IDLE holds.
- WAIT:
  - mul_a/mul_b are held constant.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: {hi,lo} <= neg ? (~mul_product + 1) : mul_product, computed at 2*WIDTH bits; state <= DONE.
- Latency: start sampled at edge E0 -> HI/LO updated at edge E0+MUL_CYCLES; done is high in the following cycle. Back-to-back start during DONE is accepted, giving a throughput of one multiply per MUL_CYCLES+1 cycles.
- start while WAIT: ignored. The issuer must honour busy.
- mthi/mtlo:
  - Accepted only in IDLE/DONE. Writes on the next edge; hi/lo update visible the following cycle.
  - mthi and mtlo in the same cycle write both with wdata.
  - Dropped in WAIT, since the architectural result is overwritten anyway.
- mthi/mtlo coinciding with start in IDLE/DONE: the move writes, and the multiply later overwrites at completion.
- mul_product is sampled only on the final WAIT edge. Its value at any other time is don't-care.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, bench multiplier model = mul_a*mul_b -> busy high 4 cycles, done pulse, hi=0xFFFFFFFE lo=0x00000001.
- MULT -3 x 5 -> mul_a=3, mul_b=5, hi=0xFFFFFFFF lo=0xFFFFFFF1; MULT -7 x -6 -> hi=0 lo=0x0000002A.
- MULT 0x80000000 x 0x80000000 -> mul_a=mul_b=0x80000000, hi=0x40000000 lo=0; MULT 0x80000000 x 1 -> hi=0xFFFFFFFF lo=0x80000000.
- start pulsed mid-WAIT with op_a=9, plus mthi wdata=0x1234 mid-WAIT -> both ignored, first result intact; back-to-back start in DONE cycle -> second result after MUL_CYCLES+1 cycles.
- From IDLE: mthi 0xAAAA5555, then mtlo 0x0F0F0F0F, then both with 0x1 -> hi/lo track each write one cycle later, finally hi=lo=1.
- rst_n low for 1 cycle during WAIT (async, mid-cycle) -> outputs 0 immediately, state IDLE, no done pulse; repeat with MUL_CYCLES=1 -> done exactly 2 cycles after start.
